window_stream_ctrl: RTL and testbench
=====================================

Name: window_stream_ctrl

Overview:
- Sequencing controller for the feature-tracker window pipeline.
- That pipeline is a chain of free-running line-delay and pixel-delay buffers, with no enable, so every buffer shifts on every clock.
- This block accepts the pixel stream, enforces gapless framing, and tracks column/row position.
- It emits position/validity tags delayed by the downstream pipeline latency, so tags line up with the window data leaving the buffers.

Parameters:
- IMG_WIDTH, 640, pixels per line; this is also the line-delay depth used in the datapath.
- IMG_HEIGHT, 480, lines per frame.
- WIN, 3, window edge size in pixels; legal range 2 to IMG_HEIGHT.
- LAT, 4, tag latency in clocks, equal to the datapath latency; minimum 1.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  input pixel present this cycle.
- sof  in  1  start of frame; qualifies the first pixel, meaningful only when pix_valid=1.
- busy  out  1  frame in progress or tags still in flight.
- err  out  1  sticky framing error.
- out_valid  out  1  tagged pixel leaving the datapath.
- out_col  out  $clog2(IMG_WIDTH)  column of the tagged pixel.
- out_row  out  $clog2(IMG_HEIGHT)  row of the tagged pixel.
- out_win_valid  out  1  WINxWIN window ending at this pixel lies fully inside the frame.
- out_eol  out  1  last pixel of a line.
- out_eof  out  1  last pixel of the frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; col=row=0; err=0.
  - Tag pipeline cleared; all outputs 0 immediately.
- FSM states IDLE, ACTIVE, RESYNC.
  - IDLE: a pixel with pix_valid & sof is accepted as (row 0, col 0). err is cleared and the FSM moves to ACTIVE. pix_valid without sof is ignored and no tag is issued.
  - ACTIVE: every cycle must carry pix_valid=1.
    - Each accepted pixel issues a tag.
    - col increments; at col=IMG_WIDTH-1 it wraps to 0 and row increments.
    - At the last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1) row and col return to 0.
    - Next state after the last pixel is IDLE. If the following cycle carries pix_valid & sof, it is accepted in IDLE with zero gap, so back-to-back frames are legal.
  - ACTIVE errors: pix_valid=0 before the last pixel, or sof=1 on any pixel other than (0,0).
    - Either sets err=1 on the next edge and moves the FSM to RESYNC.
    - The offending pixel is not tagged.
    - col and row are reset to 0.
  - RESYNC: holds until pix_valid=0, then goes to IDLE. Stream input is ignored while in RESYNC.
- Tag generation, on the accept cycle:
  - win_valid = (row>=WIN-1) && (col>=WIN-1).
  - eol = (col==IMG_WIDTH-1).
  - eof = eol && (row==IMG_HEIGHT-1).
- Tag pipeline:
  - LAT-stage shift register carrying {valid, col, row, win_valid, eol, eof}.
  - Shifts every clock, independent of FSM state.
  - A pixel accepted at edge t appears on the out_* ports from edge t+LAT.
  - Tags already in flight when an error occurs still drain. No eof tag is produced for an aborted frame.
- Registered outputs:
  - out_col, out_row and the flags are 0 whenever out_valid=0.
  - busy = (state!=IDLE) || any tag-stage valid.
- Widths: counters are sized by $clog2 and compared against IMG_WIDTH-1 and IMG_HEIGHT-1 only, so the counters never overflow.

Optional Feature:
- Macro: WINDOW_STREAM_CTRL_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt, 16 bits.
  - Reset value 0.
  - Increments on each cycle with out_valid & out_eof, wrapping at 65535 to 0.
  - Unaffected by errors.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Common parameters: IMG_WIDTH=4, IMG_HEIGHT=3, WIN=3, LAT=2.
- Reset, then sof+pix_valid at edge t and 12 continuous pixels:
  - out_valid high edges t+2..t+13.
  - out_eol at cols 3; out_win_valid only at (2,2) and (2,3).
  - out_eof at t+13; busy falls at t+14; err=0.
- pix_valid pulses with sof=0 while in IDLE -> no out_valid, busy stays 0.
- pix_valid dropped after pixel 5 (row1, col1):
  - err=1 next edge, FSM in RESYNC.
  - Tags for pixels 0..5 still emerge; no out_eof.
  - A new sof later clears err and the frame completes normally.
- sof re-asserted on pixel 6 -> err=1, pixel 6 not tagged, RESYNC until pix_valid low.
- Two frames back-to-back with zero gap -> 24 consecutive out_valid cycles, col/row restart at (0,0), two out_eof pulses. With WINDOW_STREAM_CTRL_FRAME_CNT_EN, frame_cnt reads 2.
- rst_n driven low asynchronously mid-frame (between edges) -> all outputs 0 before the next clock edge; normal operation resumes after release and sof.

Source files
------------

// File: rtl/window_stream_ctrl.sv
// window_stream_ctrl: sequencing controller for the feature-tracker window
// pipeline. Accepts a gapless pixel stream, tracks column/row, and emits
// position/validity tags delayed by LAT clocks to line up with the
// free-running line/pixel delay buffers.
// Optional: define WINDOW_STREAM_CTRL_FRAME_CNT_EN to add a 16-bit
// completed-frame counter output (frame_cnt).
module window_stream_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int WIN        = 3,
    parameter int LAT        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic                          busy,
    output logic                          err,
    output logic                          out_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic                          out_win_valid,
    output logic                          out_eol,
    output logic                          out_eof
`ifdef WINDOW_STREAM_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]                   frame_cnt
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESYNC} state_t;

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          win_valid;
        logic          eol;
        logic          eof;
    } tag_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              accept, fault;
    logic              at_eol, at_last;
    tag_t              tag_in;
    tag_t [LAT-1:0]    pipe;
    logic              any_vld;

    assign at_eol  = (col == COL_LAST);
    assign at_last = at_eol && (row == ROW_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the first pixel can never be the last (height >= 2)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACTIVE;
            ACTIVE:  if (fault) state_nxt = RESYNC;
                     else if (at_last) state_nxt = IDLE;
            RESYNC:  if (!pix_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pixel accept and framing fault (gap or stray sof mid-frame)
    always_comb begin
        accept = 1'b0;
        fault  = 1'b0;
        case (state)
            IDLE:    accept = pix_valid & sof;
            ACTIVE:  if (!pix_valid || sof) fault = 1'b1;
                     else accept = 1'b1;
            default: ;
        endcase
    end

    // Position counters; every exit from a frame leaves them at (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (fault) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (at_eol) begin
                col <= '0;
                row <= at_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Sticky error: set on a framing fault, cleared by the next accepted sof
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        err <= 1'b0;
        else if (fault)                    err <= 1'b1;
        else if (state == IDLE && accept)  err <= 1'b0;
    end

    // Tag for the pixel accepted this cycle; all-zero when nothing accepted
    always_comb begin
        tag_in = '0;
        if (accept) begin
            tag_in.valid     = 1'b1;
            tag_in.col       = col;
            tag_in.row       = row;
            tag_in.win_valid = (int'(row) >= WIN - 1) && (int'(col) >= WIN - 1);
            tag_in.eol       = at_eol;
            tag_in.eof       = at_last;
        end
    end

    // Free-running tag delay line, matching the unenabled datapath buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Any tag still in flight inside the delay line
    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < LAT; i++) any_vld = any_vld | pipe[i].valid;
    end

    // Registered outputs; tag fields are already zero for empty stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_col       <= '0;
            out_row       <= '0;
            out_win_valid <= 1'b0;
            out_eol       <= 1'b0;
            out_eof       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            out_valid     <= pipe[LAT-1].valid;
            out_col       <= pipe[LAT-1].col;
            out_row       <= pipe[LAT-1].row;
            out_win_valid <= pipe[LAT-1].win_valid;
            out_eol       <= pipe[LAT-1].eol;
            out_eof       <= pipe[LAT-1].eof;
            busy          <= (state != IDLE) || any_vld;
        end
    end

`ifdef WINDOW_STREAM_CTRL_FRAME_CNT_EN
    // Completed-frame counter, counts eof tags leaving the block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    frame_cnt <= '0;
        else if (out_valid && out_eof) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Directed bench for window_stream_ctrl with a 4x3 image, WIN=3, LAT=2.
module tb_window_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic       sof;
    logic       busy, err, out_valid;
    logic [1:0] out_col;
    logic [1:0] out_row;
    logic       out_win_valid, out_eol, out_eof;
`ifdef WINDOW_STREAM_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    window_stream_ctrl #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(3),
        .WIN       (3),
        .LAT       (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .sof          (sof),
        .busy         (busy),
        .err          (err),
        .out_valid    (out_valid),
        .out_col      (out_col),
        .out_row      (out_row),
        .out_win_valid(out_win_valid),
        .out_eol      (out_eol),
        .out_eof      (out_eof)
`ifdef WINDOW_STREAM_CTRL_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] tag_obs;
    assign tag_obs = {out_valid, out_col, out_row, out_win_valid, out_eol, out_eof};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected tag for stream pixel p (frames of 12 pixels); zero if p outside [0,n)
    function automatic logic [7:0] tagv(int p, int n);
        int c, r, q;
        logic [7:0] t;
        t = '0;
        if (p >= 0 && p < n) begin
            q = p % 12;
            c = q % 4;
            r = q / 4;
            t = {1'b1, 2'(c), 2'(r), (r >= 2 && c >= 2), (c == 3), (q == 11)};
        end
        return t;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0;
        step(); step();
        chk("rst_tag",  32'(tag_obs), 32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_err",  32'(err),     32'd0);
`ifdef WINDOW_STREAM_CTRL_FRAME_CNT_EN
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        step();
    endtask

    // One clean 12-pixel frame starting from IDLE with an empty pipeline
    task automatic frame_check(input string nm);
        for (int k = 0; k <= 14; k++) begin
            pix_valid = (k < 12); sof = (k == 0);
            step();
            chk($sformatf("%s_tag_k%0d", nm, k),  32'(tag_obs), 32'(tagv(k - 2, 12)));
            chk($sformatf("%s_busy_k%0d", nm, k), 32'(busy),    32'(k >= 1 && k <= 13));
            chk($sformatf("%s_err_k%0d", nm, k),  32'(err),     32'd0);
        end
        pix_valid = 1'b0; sof = 1'b0;
    endtask

    initial begin
        do_reset();

        // Clean frame
        frame_check("f1");

        // Stray pix_valid without sof in IDLE is ignored
        for (int k = 0; k < 6; k++) begin
            pix_valid = (k % 2 == 0); sof = 1'b0;
            step();
            chk($sformatf("idle_tag_k%0d", k),  32'(tag_obs), 32'd0);
            chk($sformatf("idle_busy_k%0d", k), 32'(busy),    32'd0);
        end

        // Gap after pixel 5: error, tags 0..5 drain, no eof
        for (int k = 0; k <= 9; k++) begin
            pix_valid = (k <= 5); sof = (k == 0);
            step();
            chk($sformatf("gap_tag_k%0d", k),  32'(tag_obs), 32'(tagv(k - 2, 6)));
            chk($sformatf("gap_err_k%0d", k),  32'(err),     32'(k >= 6));
            chk($sformatf("gap_busy_k%0d", k), 32'(busy),    32'(k >= 1 && k <= 7));
        end
        pix_valid = 1'b0; sof = 1'b0;
        step();
        frame_check("f2");

        // sof on pixel 6: error, pixel 6 untagged, RESYNC ignores sof until gap
        for (int k = 0; k <= 10; k++) begin
            pix_valid = (k <= 8); sof = (k == 0 || k == 6 || k == 7);
            step();
            chk($sformatf("sof_tag_k%0d", k),  32'(tag_obs), 32'(tagv(k - 2, 6)));
            chk($sformatf("sof_err_k%0d", k),  32'(err),     32'(k >= 6));
            chk($sformatf("sof_busy_k%0d", k), 32'(busy),    32'(k >= 1 && k <= 9));
        end
        pix_valid = 1'b0; sof = 1'b0;
        step();

        // Asynchronous reset mid-frame: outputs clear before the next edge
        for (int k = 0; k <= 6; k++) begin
            pix_valid = 1'b1; sof = (k == 0);
            step();
        end
        chk("ar_pre_tag", 32'(tag_obs), 32'(tagv(4, 12)));
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_tag",  32'(tag_obs), 32'd0);
        chk("ar_busy", 32'(busy),    32'd0);
        chk("ar_err",  32'(err),     32'd0);
        pix_valid = 1'b0; sof = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        frame_check("f3");

        // Two frames back-to-back with zero gap
        do_reset();
        for (int k = 0; k <= 27; k++) begin
            pix_valid = (k < 24); sof = (k == 0 || k == 12);
            step();
            chk($sformatf("b2b_tag_k%0d", k),  32'(tag_obs), 32'(tagv(k - 2, 24)));
            chk($sformatf("b2b_busy_k%0d", k), 32'(busy),    32'(k >= 1 && k <= 25));
        end
        chk("b2b_err", 32'(err), 32'd0);
`ifdef WINDOW_STREAM_CTRL_FRAME_CNT_EN
        chk("b2b_fcnt", 32'(frame_cnt), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
